// File: rtl/bidir_pad_ctrl.sv
// Half-duplex fabric controller for one bidirectional pad cell.
// Sequences the turnaround so O_EN and I_EN never overlap, serialises a
// valid/ready bit stream onto the pad and returns synchronised samples.
module bidir_pad_ctrl #(
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic QCK,
  input  logic QRT_N,
  input  logic TX_VALID,
  input  logic TX_DATA,
  output logic TX_READY,
  output logic RX_DAT,
  output logic RX_VALID,
  output logic DIR_TX,
  output logic O_DAT,
  output logic O_EN,
  output logic I_EN,
  input  logic I_DAT
);

  localparam int CW = $clog2(TURN_CYCLES + 1);
  localparam int FW = $clog2(SYNC_STAGES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(TURN_CYCLES - 1);
  localparam logic [FW-1:0] FILL_MAX = FW'(SYNC_STAGES);

  typedef enum logic [1:0] {S_RX, S_TURN_TX, S_TX, S_TURN_RX} state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic tx_ready_q, tx_ready_d;
  logic rx_valid_q, rx_valid_d;
  logic dir_tx_q, dir_tx_d;
  logic o_dat_q, o_dat_d;
  logic o_en_q, o_en_d;
  logic i_en_q, i_en_d;

  // Next-state: direction changes always pass through a dead-time state.
  // The counter only decrements while nonzero, so it cannot wrap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_RX: begin
        if (TX_VALID) begin
          state_d = S_TURN_TX;
          cnt_d   = CNT_LOAD;
        end
      end
      S_TURN_TX: begin
        if (cnt_q == '0) state_d = S_TX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_TX: begin
        if (!TX_VALID) begin
          state_d = S_TURN_RX;
          cnt_d   = CNT_LOAD;
        end
      end
      S_TURN_RX: begin
        if (cnt_q == '0) state_d = S_RX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = S_RX;
    endcase
  end

  // Registered outputs are decoded from the next state so they line up
  // with the state register; reset forces them all low.
  always_comb begin
    o_en_d     = (state_d == S_TX);
    tx_ready_d = (state_d == S_TX);
    i_en_d     = (state_d == S_RX);
    dir_tx_d   = (state_d != S_RX);

    // Pad data: captured on handshake, held otherwise, cleared entering RX.
    o_dat_d = o_dat_q;
    if (tx_ready_q && TX_VALID) o_dat_d = TX_DATA;
    if (state_q != S_RX && state_d == S_RX) o_dat_d = 1'b0;

    // Fill count: edges spent listening, saturating; cleared leaving RX.
    fill_d = fill_q;
    if (state_d != S_RX)
      fill_d = '0;
    else if (state_q == S_RX && i_en_q && fill_q != FILL_MAX)
      fill_d = fill_q + 1'b1;
    rx_valid_d = (state_d == S_RX) && (fill_d == FILL_MAX);
  end

  // Synchroniser shift; runs every cycle regardless of direction.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], I_DAT};
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge QCK) begin
    if (!QRT_N) begin
      state_q    <= S_RX;
      cnt_q      <= '0;
      fill_q     <= '0;
      sync_q     <= '0;
      tx_ready_q <= 1'b0;
      rx_valid_q <= 1'b0;
      dir_tx_q   <= 1'b0;
      o_dat_q    <= 1'b0;
      o_en_q     <= 1'b0;
      i_en_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      fill_q     <= fill_d;
      sync_q     <= sync_d;
      tx_ready_q <= tx_ready_d;
      rx_valid_q <= rx_valid_d;
      dir_tx_q   <= dir_tx_d;
      o_dat_q    <= o_dat_d;
      o_en_q     <= o_en_d;
      i_en_q     <= i_en_d;
    end
  end

  assign TX_READY = tx_ready_q;
  assign RX_DAT   = sync_q[SYNC_STAGES-1];
  assign RX_VALID = rx_valid_q;
  assign DIR_TX   = dir_tx_q;
  assign O_DAT    = o_dat_q;
  assign O_EN     = o_en_q;
  assign I_EN     = i_en_q;

endmodule

// File: tb/tb_bidir_pad_ctrl.sv
// Bench for bidir_pad_ctrl: two configurations share the stimulus; a
// behavioural model tracks direction phases and dead time per config.
module tb_bidir_pad_ctrl;

  logic QCK, QRT_N, TX_VALID, TX_DATA, I_DAT;
  logic [1:0] tx_ready, rx_dat, rx_valid, dir_tx, o_dat, o_en, i_en;

  int checks = 0;
  int failures = 0;

  bidir_pad_ctrl #(.TURN_CYCLES(2), .SYNC_STAGES(2)) dut_a (
    .QCK(QCK), .QRT_N(QRT_N), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
    .TX_READY(tx_ready[0]), .RX_DAT(rx_dat[0]), .RX_VALID(rx_valid[0]),
    .DIR_TX(dir_tx[0]), .O_DAT(o_dat[0]), .O_EN(o_en[0]), .I_EN(i_en[0]),
    .I_DAT(I_DAT));

  bidir_pad_ctrl #(.TURN_CYCLES(1), .SYNC_STAGES(4)) dut_b (
    .QCK(QCK), .QRT_N(QRT_N), .TX_VALID(TX_VALID), .TX_DATA(TX_DATA),
    .TX_READY(tx_ready[1]), .RX_DAT(rx_dat[1]), .RX_VALID(rx_valid[1]),
    .DIR_TX(dir_tx[1]), .O_DAT(o_dat[1]), .O_EN(o_en[1]), .I_EN(i_en[1]),
    .I_DAT(I_DAT));

  initial begin
    QCK = 1'b0;
    forever #5 QCK = ~QCK;
  end

  // Model: phase of the pad (listening / going out / driving / coming back),
  // dead cycles left, edges listened, last driven bit, input history.
  localparam int P_LISTEN = 0, P_TO_TX = 1, P_DRIVE = 2, P_TO_RX = 3;
  typedef struct {
    int       phase;
    int       dead_left;
    int       listened;
    bit       odat;
    bit       in_rst;
    bit [3:0] hist;
  } mdl_t;
  mdl_t m[2];

  function automatic int tc_of(int k); return (k == 0) ? 2 : 1; endfunction
  function automatic int ss_of(int k); return (k == 0) ? 2 : 4; endfunction

  task automatic model_step(input int k);
    bit listening;
    if (!QRT_N) begin
      m[k].phase = P_LISTEN; m[k].dead_left = 0; m[k].listened = 0;
      m[k].odat = 1'b0; m[k].in_rst = 1'b1; m[k].hist = 4'b0;
    end else begin
      listening = !m[k].in_rst && m[k].phase == P_LISTEN;
      m[k].in_rst = 1'b0;
      m[k].hist = {m[k].hist[2:0], I_DAT};
      case (m[k].phase)
        P_LISTEN:
          if (TX_VALID) begin
            m[k].phase = P_TO_TX; m[k].dead_left = tc_of(k); m[k].listened = 0;
          end else if (listening && m[k].listened < ss_of(k)) begin
            m[k].listened++;
          end
        P_TO_TX: begin
          m[k].dead_left--;
          if (m[k].dead_left == 0) m[k].phase = P_DRIVE;
        end
        P_DRIVE:
          if (TX_VALID) m[k].odat = TX_DATA;
          else begin m[k].phase = P_TO_RX; m[k].dead_left = tc_of(k); end
        default: begin
          m[k].dead_left--;
          if (m[k].dead_left == 0) begin
            m[k].phase = P_LISTEN; m[k].odat = 1'b0; m[k].listened = 0;
          end
        end
      endcase
    end
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_model(input int k);
    bit run, drv;
    run = !m[k].in_rst;
    drv = run && m[k].phase == P_DRIVE;
    chk($sformatf("m%0d_tx_ready", k), tx_ready[k], drv);
    chk($sformatf("m%0d_o_en", k), o_en[k], drv);
    chk($sformatf("m%0d_i_en", k), i_en[k], run && m[k].phase == P_LISTEN);
    chk($sformatf("m%0d_dir_tx", k), dir_tx[k], run && m[k].phase != P_LISTEN);
    chk($sformatf("m%0d_o_dat", k), o_dat[k], m[k].odat);
    chk($sformatf("m%0d_rx_dat", k), rx_dat[k], m[k].hist[ss_of(k)-1]);
    chk($sformatf("m%0d_rx_valid", k), rx_valid[k],
        run && m[k].phase == P_LISTEN && m[k].listened == ss_of(k));
    chk($sformatf("m%0d_no_overlap", k), o_en[k] & i_en[k], 1'b0);
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge.
  task automatic cyc();
    @(posedge QCK);
    model_step(0);
    model_step(1);
    @(negedge QCK);
    check_model(0);
    check_model(1);
  endtask

  initial begin
    QRT_N = 1'b0; TX_VALID = 1'b0; TX_DATA = 1'b0; I_DAT = 1'b1;
    cyc(); cyc();
    chk("rst_i_en", i_en[0], 1'b0);      chk("rst_o_en", o_en[0], 1'b0);
    chk("rst_dir", dir_tx[0], 1'b0);     chk("rst_rx_valid", rx_valid[0], 1'b0);
    chk("rst_b_i_en", i_en[1], 1'b0);

    // Idle listening after reset release
    QRT_N = 1'b1;
    cyc(); chk("t1_i_en_a", i_en[0], 1'b1); chk("t1_i_en_b", i_en[1], 1'b1);
           chk("t1_rxv_e1", rx_valid[0], 1'b0);
    cyc(); chk("t1_rx_dat", rx_dat[0], 1'b1); chk("t1_rxv_e2", rx_valid[0], 1'b0);
    cyc(); chk("t1_rxv_e3", rx_valid[0], 1'b1);
    cyc(); chk("t6_rxv_e4", rx_valid[1], 1'b0);
    cyc(); chk("t6_rxv_e5", rx_valid[1], 1'b1);

    // Burst 1,0,1,1
    TX_VALID = 1'b1; TX_DATA = 1'b1;
    cyc(); chk("t2_i_en_fall", i_en[0], 1'b0); chk("t2_dir", dir_tx[0], 1'b1);
           chk("t2_rxv_drop", rx_valid[0], 1'b0); chk("t2_dead1", o_en[0], 1'b0);
    cyc(); chk("t2_dead2", o_en[0], 1'b0); chk("t6_b_oen", o_en[1], 1'b1);
    cyc(); chk("t2_o_en", o_en[0], 1'b1); chk("t2_ready", tx_ready[0], 1'b1);
    cyc(); chk("t2_bit0", o_dat[0], 1'b1);
    TX_DATA = 1'b0; cyc(); chk("t2_bit1", o_dat[0], 1'b0);
    TX_DATA = 1'b1; cyc(); chk("t2_bit2", o_dat[0], 1'b1);
    TX_DATA = 1'b1; cyc(); chk("t2_bit3", o_dat[0], 1'b1);

    // End of burst, return to listening
    TX_VALID = 1'b0;
    cyc(); chk("t3_o_en_drop", o_en[0], 1'b0); chk("t3_o_dat_hold", o_dat[0], 1'b1);
           chk("t3_dead1", i_en[0], 1'b0);
    cyc(); chk("t3_dead2", i_en[0], 1'b0);
    cyc(); chk("t3_i_en", i_en[0], 1'b1); chk("t3_o_dat_clr", o_dat[0], 1'b0);
           chk("t3_dir", dir_tx[0], 1'b0);
    cyc(); chk("t3_rxv_e1", rx_valid[0], 1'b0);
    cyc(); chk("t3_rxv_e2", rx_valid[0], 1'b1);

    // Re-request during turnaround back to RX
    TX_VALID = 1'b1;
    cyc(); cyc(); cyc(); chk("t4_tx", o_en[0], 1'b1);
    TX_VALID = 1'b0;
    cyc(); cyc();
    TX_VALID = 1'b1;
    cyc(); chk("t4_pulse", i_en[0], 1'b1);
    cyc(); chk("t4_pulse_end", i_en[0], 1'b0);
    cyc(); chk("t4_dead2", o_en[0], 1'b0);
    cyc(); chk("t4_tx_again", o_en[0], 1'b1);

    // Reset while driving a 1
    TX_DATA = 1'b1;
    cyc(); chk("t5_o_dat", o_dat[0], 1'b1);
    QRT_N = 1'b0;
    cyc(); chk("t5_o_en", o_en[0], 1'b0); chk("t5_o_dat0", o_dat[0], 1'b0);
           chk("t5_ready", tx_ready[0], 1'b0); chk("t5_rxv", rx_valid[0], 1'b0);
           chk("t5_i_en", i_en[0], 1'b0);
    QRT_N = 1'b1;
    cyc(); chk("t5_rel_dir", dir_tx[0], 1'b1); chk("t5_rel_i_en", i_en[0], 1'b0);

    // Random traffic against the model
    for (int i = 0; i < 800; i++) begin
      QRT_N = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 5) == 0) TX_VALID = ~TX_VALID;
      TX_DATA = 1'($urandom);
      I_DAT = 1'($urandom);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
